// File: rtl/vga_cam_pkg.sv
// ============================================================================
// Module   : vga_cam_pkg
// Brief    : Shared frame geometry, capture state encoding and pixel type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vga_cam_pkg;

    localparam int H_PIX_DEF   = 320;
    localparam int V_LINES_DEF = 240;
    localparam int FB_ADDR_W   = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        CAPT = 2'd2
    } cam_state_e;

    typedef logic [15:0] rgb565_t;

endpackage

`default_nettype wire

// File: rtl/cam_edge_detect.sv
// ============================================================================
// Module   : cam_edge_detect
// Brief    : Registers one camera control input and flags its edges.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cam_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_q    <= i_d;
            r_prev <= r_q;
        end
    end

    assign o_q    = r_q;
    assign o_rise = r_q & ~r_prev;
    assign o_fall = ~r_q & r_prev;

endmodule

`default_nettype wire

// File: rtl/ov7670_frame_writer.sv
// ============================================================================
// Module   : ov7670_frame_writer
// Brief    : Pairs OV7670 RGB565 bytes into pixels and writes the frame buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ov7670_frame_writer
    import vga_cam_pkg::*;
#(
    parameter int H_PIX   = H_PIX_DEF,
    parameter int V_LINES = V_LINES_DEF,
    parameter int ADDR_W  = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              we,
    output logic [ADDR_W-1:0] w_addr,
    output rgb565_t           w_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int XW = $clog2(H_PIX + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam logic [XW-1:0]     C_X_MAX     = XW'(H_PIX);
    localparam logic [YW-1:0]     C_Y_MAX     = YW'(V_LINES);
    localparam logic [ADDR_W-1:0] C_LINE_STEP = ADDR_W'(H_PIX);

    generate
        if ((2 ** ADDR_W) < (H_PIX * V_LINES)) begin : g_addr_w_check
            $error("ADDR_W too small for H_PIX*V_LINES");
        end
    endgenerate

    logic w_vs_q, w_vs_rise, w_vs_fall;
    logic w_href_q, w_href_rise, w_href_fall;
    logic w_unused;

    cam_edge_detect u_vsync_edge (
        .clk    (clk),
        .reset  (reset),
        .i_d    (cam_vsync),
        .o_q    (w_vs_q),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall)
    );

    cam_edge_detect u_href_edge (
        .clk    (clk),
        .reset  (reset),
        .i_d    (cam_href),
        .o_q    (w_href_q),
        .o_rise (w_href_rise),
        .o_fall (w_href_fall)
    );

    assign w_unused = ^{w_vs_q, w_href_rise};

    cam_state_e        r_state;
    logic [7:0]        r_data_q;
    logic [7:0]        r_hi_byte;
    logic              r_byte_phase;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [ADDR_W-1:0] r_line_base;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_data_q     <= '0;
            r_hi_byte    <= '0;
            r_byte_phase <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_line_base  <= '0;
            we           <= 1'b0;
            w_addr       <= '0;
            w_data       <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            r_data_q   <= cam_data;
            we         <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (capture_en) r_state <= SYNC;
                end
                SYNC: begin
                    if (!capture_en) begin
                        r_state <= IDLE;
                    end else if (w_vs_fall) begin
                        r_state      <= CAPT;
                        busy         <= 1'b1;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_line_base  <= '0;
                        r_byte_phase <= 1'b0;
                        overflow     <= 1'b0;
                    end
                end
                CAPT: begin
                    // A vsync rise ends the frame at once; only an already-paired pixel still lands.
                    if (w_vs_rise) begin
                        r_state    <= capture_en ? SYNC : IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (w_href_q) begin
                        r_byte_phase <= ~r_byte_phase;
                        if (!r_byte_phase) begin
                            r_hi_byte <= r_data_q;
                        end else begin
                            if ((r_x < C_X_MAX) && (r_y < C_Y_MAX)) begin
                                we     <= 1'b1;
                                w_addr <= r_line_base + ADDR_W'(r_x);
                                w_data <= {r_hi_byte, r_data_q};
                            end else begin
                                overflow <= 1'b1;
                            end
                            if (r_x < C_X_MAX) r_x <= r_x + XW'(1);
                        end
                    end
                    // Line end also drops any dangling odd byte via the phase reset.
                    if (w_href_fall) begin
                        r_x          <= '0;
                        r_byte_phase <= 1'b0;
                        if (r_y < C_Y_MAX) begin
                            r_y         <= r_y + YW'(1);
                            r_line_base <= r_line_base + C_LINE_STEP;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ov7670_frame_writer.sv
// ============================================================================
// Module   : tb_ov7670_frame_writer
// Brief    : Directed self-checking bench for ov7670_frame_writer (reduced frame size).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ov7670_frame_writer;

    localparam int H  = 16;
    localparam int V  = 6;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          capture_en;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic          we;
    logic [AW-1:0] w_addr;
    logic [15:0]   w_data;
    logic          busy;
    logic          frame_done;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    int   log_addr[$];
    int   log_data[$];
    int   fd_cnt  = 0;
    int   dbl_we  = 0;
    logic prev_we = 1'b0;

    always #5 clk = ~clk;

    ov7670_frame_writer #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .capture_en (capture_en),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .we         (we),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always @(negedge clk) begin
        if (we) begin
            log_addr.push_back(int'(w_addr));
            log_data.push_back(int'(w_data));
        end
        if (we && prev_we) dbl_we <= dbl_we + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        prev_we <= we;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        cam_vsync = 1'b1;
        tick(3);
        cam_vsync = 1'b0;
        tick(3);
    endtask

    task automatic end_frame();
        cam_vsync = 1'b1;
        tick(4);
    endtask

    // Pixel k = y*H + x is sent as {k[15:8], k[7:0]}, so a correct write has data == address.
    task automatic send_line(input int nbytes, input int y);
        logic [15:0] kv;
        for (int i = 0; i < nbytes; i++) begin
            kv       = 16'(y * H + i / 2);
            cam_href = 1'b1;
            cam_data = (i % 2 == 0) ? kv[15:8] : kv[7:0];
            tick(1);
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1; capture_en = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
        tick(3);
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", we); end
        checks++; if (w_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", w_addr); end
        checks++; if (w_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", w_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%0b exp=0", frame_done); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_pairing_latency();
        capture_en = 1'b1;
        cam_vsync  = 1'b1;
        tick(3);
        cam_vsync = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_early got=%0b exp=0", busy); end
        tick(1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_rise got=%0b exp=1", busy); end
        tick(2);
        cam_href = 1'b1; cam_data = 8'hF8;
        tick(1);
        cam_data = 8'h1F;
        tick(1);
        cam_href = 1'b0; cam_data = 8'h00;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL pair_we_early got=%0b exp=0", we); end
        tick(1);
        checks++; if (we !== 1'b1) begin failures++; $display("FAIL pair_we got=%0b exp=1", we); end
        checks++; if (w_addr !== 17'd0) begin failures++; $display("FAIL pair_addr got=%0h exp=0", w_addr); end
        checks++; if (w_data !== 16'hF81F) begin failures++; $display("FAIL pair_data got=%0h exp=f81f", w_data); end
        tick(1);
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL pair_we_after got=%0b exp=0", we); end
        tick(3);
        cam_vsync = 1'b1;
        tick(1);
        checks++; if ({frame_done, busy} !== 2'b01) begin failures++; $display("FAIL fd_early got=%b exp=01", {frame_done, busy}); end
        tick(1);
        checks++; if ({frame_done, busy} !== 2'b10) begin failures++; $display("FAIL fd_pulse got=%b exp=10", {frame_done, busy}); end
        tick(1);
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL fd_width got=%0b exp=0", frame_done); end
        tick(2);
    endtask

    task automatic test_full_frame();
        int base = log_addr.size();
        int fd0  = fd_cnt;
        int bad  = 0;
        int n;
        start_frame();
        for (int y = 0; y < V; y++) send_line(2 * H, y);
        end_frame();
        n = log_addr.size() - base;
        for (int i = 0; i < n; i++)
            if (log_addr[base + i] != i || log_data[base + i] != i) bad++;
        checks++; if (n != H * V) begin failures++; $display("FAIL full_count got=%0d exp=%0d", n, H * V); end
        checks++; if (bad != 0) begin failures++; $display("FAIL full_seq bad=%0d exp=0", bad); end
        checks++; if (n > 0 && log_addr[log_addr.size() - 1] != H * V - 1) begin
            failures++; $display("FAIL full_last got=%0d exp=%0d", log_addr[log_addr.size() - 1], H * V - 1); end
        checks++; if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL full_fd got=%0d exp=1", fd_cnt - fd0); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_ovf got=%0b exp=0", overflow); end
        checks++; if (w_addr !== 17'(H * V - 1)) begin failures++; $display("FAIL addr_hold got=%0d exp=%0d", w_addr, H * V - 1); end
        checks++; if (w_data !== 16'(H * V - 1)) begin failures++; $display("FAIL data_hold got=%0h exp=%0h", w_data, H * V - 1); end
    endtask

    task automatic test_short_odd();
        int base = log_addr.size();
        int bad  = 0;
        int n;
        start_frame();
        send_line(5, 0);
        send_line(2 * H, 1);
        end_frame();
        n = log_addr.size() - base;
        checks++; if (n != H + 2) begin failures++; $display("FAIL short_count got=%0d exp=%0d", n, H + 2); end
        if (n == H + 2) begin
            for (int i = 0; i < H; i++) if (log_addr[base + 2 + i] != H + i) bad++;
            if (log_addr[base] != 0 || log_addr[base + 1] != 1) bad++;
            for (int i = 0; i < n; i++) if (log_data[base + i] != log_addr[base + i]) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL short_addrs bad=%0d exp=0", bad); end
    endtask

    task automatic test_overflow();
        int base = log_addr.size();
        int mx   = -1;
        int bad  = 0;
        int n;
        start_frame();
        send_line(2 * H + 4, 0);
        n = log_addr.size() - base;
        for (int i = 0; i < n; i++) if (log_addr[base + i] > mx) mx = log_addr[base + i];
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
        checks++; if (n != H || mx != H - 1) begin failures++; $display("FAIL ovf_line0 n=%0d max=%0d exp n=%0d max=%0d", n, mx, H, H - 1); end
        for (int y = 1; y <= V + 1; y++) send_line(2 * H, y);
        end_frame();
        n = log_addr.size() - base;
        for (int i = 0; i < n; i++) begin
            if (log_addr[base + i] > mx) mx = log_addr[base + i];
            if (log_data[base + i] != log_addr[base + i]) bad++;
        end
        checks++; if (n != H * V || mx != H * V - 1) begin failures++; $display("FAIL ovf_total n=%0d max=%0d exp n=%0d max=%0d", n, mx, H * V, H * V - 1); end
        checks++; if (bad != 0) begin failures++; $display("FAIL ovf_data bad=%0d exp=0", bad); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
        start_frame();
        checks++; if ({busy, overflow} !== 2'b10) begin failures++; $display("FAIL ovf_clear got=%b exp=10", {busy, overflow}); end
        end_frame();
    endtask

    task automatic test_capture_drop();
        int base = log_addr.size();
        int fd0  = fd_cnt;
        start_frame();
        send_line(2 * H, 0);
        capture_en = 1'b0;
        send_line(2 * H, 1);
        end_frame();
        checks++; if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL drop_fd got=%0d exp=1", fd_cnt - fd0); end
        checks++; if (log_addr.size() - base != 2 * H) begin failures++; $display("FAIL drop_count got=%0d exp=%0d", log_addr.size() - base, 2 * H); end
        start_frame();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy got=%0b exp=0", busy); end
        send_line(2 * H, 0);
        end_frame();
        checks++; if (log_addr.size() - base != 2 * H) begin failures++; $display("FAIL drop_idle_wr got=%0d exp=%0d", log_addr.size() - base, 2 * H); end
        checks++; if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL drop_idle_fd got=%0d exp=1", fd_cnt - fd0); end
    endtask

    task automatic test_reset_mid();
        int base;
        capture_en = 1'b1;
        start_frame();
        base = log_addr.size();
        cam_href = 1'b1; cam_data = 8'h12;
        tick(1);
        cam_data = 8'h34;
        tick(1);
        reset = 1'b1;
        tick(1);
        checks++; if ({we, busy, frame_done, overflow} !== 4'b0000) begin
            failures++; $display("FAIL rstmid_flags got=%b exp=0000", {we, busy, frame_done, overflow}); end
        checks++; if (w_addr !== '0 || w_data !== 16'h0) begin
            failures++; $display("FAIL rstmid_bus addr=%0h data=%0h exp=0", w_addr, w_data); end
        cam_data = 8'h56;
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin cam_data = 8'(i); tick(1); end
        cam_href = 1'b0;
        tick(4);
        send_line(2 * H, 0);
        checks++; if (log_addr.size() != base) begin failures++; $display("FAIL rstmid_nowr got=%0d exp=0", log_addr.size() - base); end
        start_frame();
        send_line(4, 0);
        end_frame();
        checks++; if (log_addr.size() - base != 2 || log_addr[log_addr.size() - 1] != 1) begin
            failures++; $display("FAIL rstmid_resume n=%0d exp=2", log_addr.size() - base); end
    endtask

    initial begin
        test_reset();
        test_pairing_latency();
        test_full_frame();
        test_short_odd();
        test_overflow();
        test_capture_drop();
        test_reset_mid();
        tick(2);
        checks++; if (dbl_we != 0) begin failures++; $display("FAIL we_back_to_back got=%0d exp=0", dbl_we); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ov7670_frame_writer.md
# ov7670_frame_writer

Capture-side counterpart of the display image reader: takes the OV7670 byte stream (vsync/href/8-bit data, RGB565, two bytes per pixel) and writes one 16-bit pixel word per pixel into the frame buffer RAM. The write port uses the same 17-bit address and 16-bit data layout the VGA read path consumes, so the frame buffer becomes a drop-in replacement for the static image ROM. The block is clocked by the camera pixel clock, which is the write-side clock of the dual-port frame buffer.

## Interface
Parameters:
- H_PIX, 320, active pixels per line
- V_LINES, 240, active lines per frame
- ADDR_W, 17, frame buffer address width; must satisfy 2**ADDR_W >= H_PIX*V_LINES

Ports:
- clk  in  1  camera pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- capture_en  in  1  level; high = capture frames continuously, low = finish the current frame, then idle
- cam_vsync  in  1  camera vsync, high during vertical blanking
- cam_href  in  1  camera href, high during active line bytes
- cam_data  in  8  camera byte, valid when cam_href is high
- we  out  1  frame buffer write enable, one-cycle pulse per pixel
- w_addr  out  ADDR_W  write address, line-major, addr = y*H_PIX + x
- w_data  out  16  RGB565 pixel word, {first byte, second byte}
- busy  out  1  high while in CAPT
- frame_done  out  1  one-cycle pulse at the end of each captured frame
- overflow  out  1  sticky; set by the first out-of-window pixel, cleared only by reset or the start of a frame

## Operation
- Reset: all outputs 0; state IDLE; x, line_base, y, byte_phase, and edge-detect registers 0.
- Inputs are registered once (vsync_q, href_q, data_q). Edges are detected from the previous registered value.
- State machine (2-bit enum):
  - IDLE: go to SYNC when capture_en = 1.
  - SYNC: go to CAPT on a vsync falling edge. Clear x, y, line_base, byte_phase, and overflow. If capture_en drops, go back to IDLE.
  - CAPT: go to SYNC on a vsync rising edge if capture_en = 1, otherwise go to IDLE. frame_done pulses on that transition.
- Byte pairing: in CAPT, while href_q = 1, toggle byte_phase on every cycle.
  - phase 0: latch data_q into hi_byte.
  - phase 1: form the pixel {hi_byte, data_q}.
- Write: on a phase-1 byte, when x < H_PIX and y < V_LINES, the next cycle drives we = 1, w_addr = line_base + x, w_data = pixel. x then increments.
  - If x >= H_PIX or y >= V_LINES, the write is suppressed, overflow is set, and x still increments, saturating at H_PIX.
- Line end: on an href falling edge in CAPT, x <= 0, byte_phase <= 0, y <= y + 1, and line_base <= line_base + H_PIX.
  - y saturates at V_LINES; line_base freezes once y reaches V_LINES.
  - No multiplier is used.
- Odd byte count on a line: the dangling phase-0 byte is discarded and no write is issued.
- Short lines (fewer than H_PIX pixels): the remainder of the line is left unwritten. The next line still starts at the correct line_base.
- Extra lines beyond V_LINES: suppressed and flagged overflow.
- A vsync rising edge mid-line ends the frame immediately. Any pending pixel that already completed phase 1 is still written on the following cycle.
- Reset mid-frame: everything returns to reset values on the next edge. A pending write is dropped.

## Timing
- Latency: camera byte at pins in cycle n → data_q in n+1 → for a phase-1 byte, we/w_addr/w_data valid during cycle n+2.
- Maximum write rate is one write every 2 cycles. we is never high in two consecutive cycles.
- w_addr and w_data hold their last value when we = 0.
- frame_done is asserted in the cycle after the vsync_q rising edge is detected, together with busy falling.
- busy rises in the cycle after the vsync falling edge is detected.
- Simultaneous href falling edge and vsync rising edge: the line-end update and the frame end both apply. The state leaves CAPT, and y/line_base are cleared at the next SYNC→CAPT transition.

## Structure
- Shared package vga_cam_pkg holds:
  - H_PIX_DEF = 320, V_LINES_DEF = 240, FB_ADDR_W = 17
  - typedef enum logic [1:0] {IDLE, SYNC, CAPT} cam_state_e
  - typedef logic [15:0] rgb565_t
- One sub-module, cam_edge_detect: a registered input stage that outputs the registered level plus rise/fall pulses. It is instantiated for vsync and href.
- The frame buffer RAM is outside this block.

## Test plan
- Full frame: capture_en = 1, vsync pulse, 240 lines of 640 bytes where byte pair k = {k[15:8], k[7:0]}.
  - Expected: exactly 76800 writes, the last at w_addr 76799, w_data matching; one frame_done; overflow = 0.
- Byte pairing and latency: a single line with bytes 0xF8, 0x1F.
  - Expected: we high exactly 2 cycles after 0x1F is at the pins, w_addr 0, w_data 0xF81F.
- Short and odd lines: line 0 has 5 bytes, line 1 has a full 640 bytes.
  - Expected: addresses 0 and 1 written, no write for byte 5; line 1 writes 320..639.
- Overflow: a line of 644 bytes followed by 241 full lines.
  - Expected: writes never exceed address 319 within the first line or 76799 overall; overflow = 1 after pixel 320; the next frame start clears it.
- capture_en dropped mid-frame.
  - Expected: the frame completes; frame_done pulses; state goes to IDLE; no writes during the following frame.
- Reset mid-line.
  - Expected: we = 0 and all outputs 0 on the next cycle; no writes until a new vsync falling edge with capture_en = 1.
